// File: rtl/adc_sample_sched.sv
// -----------------------------------------------------------------------------
// adc_sample_sched
//
// Periodic two-channel ADC sample scheduler. A free-running tick counter fires
// every INTERVAL cycles; on an accepted tick both channel inputs are snapshotted
// and written into their ring buffers in the shared data RAM via the ADC write
// port. The ch0 (EMG) sample is written first, then the ch1 (ECG) sample. CPU
// stores always win the RAM port, so each pending write waits until the CPU
// releases the port. A tick that arrives while a pair is still pending is
// dropped and counted.
//
// Parameters:
//   INTERVAL  clock cycles between sample ticks (>= 4)
//   DEPTH     entries per channel ring buffer (2..1024)
//   CH0_BASE  RAM word address of ch0 buffer entry 0
//   CH1_BASE  RAM word address of ch1 buffer entry 0
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   enable_i       tick generation enable (counter held at 0 when low)
//   ch0_data_i     EMG sample, continuously valid
//   ch1_data_i     ECG sample, continuously valid
//   cpu_wen_i      CPU store this cycle; blocks the ADC write
//   ram_wen_o      ADC write strobe to RAM
//   ram_addr_o     ADC write word address
//   ram_data_o     ADC write data
//   ch0_ptr_o      next ch0 write index
//   ch1_ptr_o      next ch1 write index
//   frame_done_o   one-cycle pulse after the ch1 buffer wraps
//   overrun_cnt_o  saturating count of dropped ticks
//
// Optional feature (macro ADC_SAMPLE_SCHED_TIMESTAMP_EN):
//   When defined, a 16-bit accepted-tick index is kept and each written word
//   becomes {tick_index, sample[15:0]}; both words of a pair carry the same
//   index. When undefined, the full 32-bit sample is written.
// -----------------------------------------------------------------------------
module adc_sample_sched #(
  parameter int unsigned INTERVAL = 125000,
  parameter int unsigned DEPTH    = 640,
  parameter logic [11:0] CH0_BASE = 12'h800,
  parameter logic [11:0] CH1_BASE = 12'hA80
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [31:0] ch0_data_i,
  input  logic [31:0] ch1_data_i,
  input  logic        cpu_wen_i,
  output logic        ram_wen_o,
  output logic [11:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [9:0]  ch0_ptr_o,
  output logic [9:0]  ch1_ptr_o,
  output logic        frame_done_o,
  output logic [7:0]  overrun_cnt_o
);

  localparam int unsigned     CNT_W    = $clog2(INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
  localparam logic [9:0]      PTR_LAST = 10'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND0 = 2'd1,
    PEND1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      snap0_q, snap0_d;
  logic [31:0]      snap1_q, snap1_d;
  logic [9:0]       ch0_ptr_q, ch0_ptr_d;
  logic [9:0]       ch1_ptr_q, ch1_ptr_d;
  logic [11:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       overrun_q, overrun_d;

  logic             tick;
  logic             accept;
  logic [31:0]      cap0, cap1;

  function automatic logic [9:0] ptr_inc(input logic [9:0] p);
    return (p == PTR_LAST) ? 10'd0 : p + 10'd1;
  endfunction

  assign tick   = enable_i && (cnt_q == CNT_LAST);
  assign accept = tick && (state_q == IDLE);
  assign cnt_d  = (!enable_i || tick) ? '0 : cnt_q + CNT_W'(1);

  // Word captured into each snapshot on an accepted tick.
`ifdef ADC_SAMPLE_SCHED_TIMESTAMP_EN
  logic [15:0] tick_idx_q, tick_idx_d;
  logic        unused_sample_hi;

  assign cap0             = {tick_idx_q, ch0_data_i[15:0]};
  assign cap1             = {tick_idx_q, ch1_data_i[15:0]};
  assign tick_idx_d       = accept ? tick_idx_q + 16'd1 : tick_idx_q;
  assign unused_sample_hi = ^{ch0_data_i[31:16], ch1_data_i[31:16]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tick_idx_q <= '0;
    else       tick_idx_q <= tick_idx_d;
  end
`else
  assign cap0 = ch0_data_i;
  assign cap1 = ch1_data_i;
`endif

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      snap0_q      <= '0;
      snap1_q      <= '0;
      ch0_ptr_q    <= '0;
      ch1_ptr_q    <= '0;
      addr_q       <= CH0_BASE;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap0_q      <= snap0_d;
      snap1_q      <= snap1_d;
      ch0_ptr_q    <= ch0_ptr_d;
      ch1_ptr_q    <= ch1_ptr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    snap0_d      = snap0_q;
    snap1_d      = snap1_q;
    ch0_ptr_d    = ch0_ptr_q;
    ch1_ptr_d    = ch1_ptr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    // A tick landing on a pending pair is lost; the pair in flight is kept.
    if (tick && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    // Remember the last issued write so the port holds it while idle.
    if (ram_wen_o) begin
      addr_d = ram_addr_o;
      data_d = ram_data_o;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          snap0_d = cap0;
          snap1_d = cap1;
          state_d = PEND0;
        end
      end
      PEND0: begin
        if (ram_wen_o) begin
          ch0_ptr_d = ptr_inc(ch0_ptr_q);
          state_d   = PEND1;
        end
      end
      PEND1: begin
        if (ram_wen_o) begin
          ch1_ptr_d    = ptr_inc(ch1_ptr_q);
          frame_done_d = (ch1_ptr_q == PTR_LAST);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the write strobe yields to the CPU combinationally.
  always_comb begin
    ram_wen_o  = 1'b0;
    ram_addr_o = addr_q;
    ram_data_o = data_q;
    case (state_q)
      PEND0: begin
        ram_wen_o  = !cpu_wen_i;
        ram_addr_o = CH0_BASE + {2'b00, ch0_ptr_q};
        ram_data_o = snap0_q;
      end
      PEND1: begin
        ram_wen_o  = !cpu_wen_i;
        ram_addr_o = CH1_BASE + {2'b00, ch1_ptr_q};
        ram_data_o = snap1_q;
      end
      default: ;
    endcase
  end

  assign ch0_ptr_o     = ch0_ptr_q;
  assign ch1_ptr_o     = ch1_ptr_q;
  assign frame_done_o  = frame_done_q;
  assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_adc_sample_sched.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_sched
//
// Self-checking bench for adc_sample_sched with INTERVAL=8, DEPTH=4.
// A vector table covers the first two ticks (plain pair, CPU-stalled pair);
// hand-written sequences cover buffer wrap/frame_done, overruns, reset in the
// middle of a pair, enable gating, timestamp data and overrun saturation.
// Cycle k is the clock period that follows the k-th rising edge after reset
// release; inputs change 1 time unit after a rising edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_adc_sample_sched;

  localparam int unsigned INTERVAL = 8;
  localparam int unsigned DEPTH    = 4;
`ifdef ADC_SAMPLE_SCHED_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] ch0 = '0;
  logic [31:0] ch1 = '0;
  logic        cpu_wen = 1'b0;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic [9:0]  ch0_ptr;
  logic [9:0]  ch1_ptr;
  logic        frame_done;
  logic [7:0]  overrun_cnt;

  always #5 clock = ~clock;

  adc_sample_sched #(
    .INTERVAL(INTERVAL),
    .DEPTH   (DEPTH),
    .CH0_BASE(12'h800),
    .CH1_BASE(12'hA80)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_i     (enable),
    .ch0_data_i   (ch0),
    .ch1_data_i   (ch1),
    .cpu_wen_i    (cpu_wen),
    .ram_wen_o    (ram_wen),
    .ram_addr_o   (ram_addr),
    .ram_data_o   (ram_data),
    .ch0_ptr_o    (ch0_ptr),
    .ch1_ptr_o    (ch1_ptr),
    .frame_done_o (frame_done),
    .overrun_cnt_o(overrun_cnt)
  );

  typedef struct packed {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] data;
    logic [9:0]  p0;
    logic [9:0]  p1;
    logic        fd;
    logic [7:0]  ovr;
  } out_t;

  typedef struct {
    logic        en;
    logic        cpu;
    logic [31:0] c0;
    logic [31:0] c1;
    out_t        exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [15:0] idx);
    return TS ? {idx, d[15:0]} : d;
  endfunction

  function automatic out_t mk(input logic w, input logic [11:0] a, input logic [31:0] d,
                              input logic [9:0] p0, input logic [9:0] p1,
                              input logic fd, input logic [7:0] ovr);
    out_t o;
    o.wen = w; o.addr = a; o.data = d; o.p0 = p0; o.p1 = p1; o.fd = fd; o.ovr = ovr;
    return o;
  endfunction

  function automatic out_t cur();
    return mk(ram_wen, ram_addr, ram_data, ch0_ptr, ch1_ptr, frame_done, overrun_cnt);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got wen=%b addr=%h data=%h p0=%0d p1=%0d fd=%b ovr=%0d, expected wen=%b addr=%h data=%h p0=%0d p1=%0d fd=%b ovr=%0d",
               name, cyc, act.wen, act.addr, act.data, act.p0, act.p1, act.fd, act.ovr,
               exp.wen, exp.addr, exp.data, exp.p0, exp.p1, exp.fd, exp.ovr);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tv[23];
  int   fd_cnt;
  int   wen_cnt;

  initial begin
    // ---------------- vector table: first two ticks ----------------
    for (int k = 0; k < 23; k++) begin
      tv[k].en  = 1'b1;
      tv[k].cpu = (k >= 16 && k <= 18);
      tv[k].c0  = (k < 11) ? 32'h11 : 32'h33;
      tv[k].c1  = (k < 11) ? 32'h22 : 32'h44;
    end
    for (int k = 0; k <= 7; k++) tv[k].exp = mk(0, 12'h800, 32'h0, 0, 0, 0, 0);
    tv[8].exp = mk(1, 12'h800, fmt(32'h11, 0), 0, 0, 0, 0);
    tv[9].exp = mk(1, 12'hA80, fmt(32'h22, 0), 1, 0, 0, 0);
    for (int k = 10; k <= 15; k++) tv[k].exp = mk(0, 12'hA80, fmt(32'h22, 0), 1, 1, 0, 0);
    for (int k = 16; k <= 18; k++) tv[k].exp = mk(0, 12'h801, fmt(32'h33, 1), 1, 1, 0, 0);
    tv[19].exp = mk(1, 12'h801, fmt(32'h33, 1), 1, 1, 0, 0);
    tv[20].exp = mk(1, 12'hA81, fmt(32'h44, 1), 2, 1, 0, 0);
    tv[21].exp = mk(0, 12'hA81, fmt(32'h44, 1), 2, 2, 0, 0);
    tv[22].exp = mk(0, 12'hA81, fmt(32'h44, 1), 2, 2, 0, 0);

    // ---------------- reset state ----------------
    enable = 1'b1; ch0 = 32'h11; ch1 = 32'h22; cpu_wen = 1'b0;
    @(negedge clock);
    check("reset_state", cur(), mk(0, 12'h800, 32'h0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;

    for (int k = 0; k < 23; k++) begin
      enable = tv[k].en; cpu_wen = tv[k].cpu; ch0 = tv[k].c0; ch1 = tv[k].c1;
      @(negedge clock);
      check($sformatf("vec%0d", k), cur(), tv[k].exp);
      adv();
    end

    // ---------------- ring wrap and frame_done (cycles 23..45) ----------------
    fd_cnt = 0;
    for (int k = 23; k <= 45; k++) begin
      cpu_wen = 1'b0;
      ch0 = (k < 26) ? 32'h55 : (k < 36) ? 32'h77 : 32'h99;
      ch1 = (k < 26) ? 32'h66 : (k < 36) ? 32'h88 : 32'hAA;
      @(negedge clock);
      fd_cnt += int'(frame_done);
      case (k)
        24: check("wrap_ch0_802", cur(), mk(1, 12'h802, fmt(32'h55, 2), 2, 2, 0, 0));
        25: check("wrap_ch1_A82", cur(), mk(1, 12'hA82, fmt(32'h66, 2), 3, 2, 0, 0));
        32: check("wrap_ch0_803", cur(), mk(1, 12'h803, fmt(32'h77, 3), 3, 3, 0, 0));
        33: check("wrap_ch1_A83", cur(), mk(1, 12'hA83, fmt(32'h88, 3), 0, 3, 0, 0));
        34: check("frame_done_hi", cur(), mk(0, 12'hA83, fmt(32'h88, 3), 0, 0, 1, 0));
        35: check("frame_done_lo", cur(), mk(0, 12'hA83, fmt(32'h88, 3), 0, 0, 0, 0));
        40: check("after_wrap_800", cur(), mk(1, 12'h800, fmt(32'h99, 4), 0, 0, 0, 0));
        41: check("after_wrap_A80", cur(), mk(1, 12'hA80, fmt(32'hAA, 4), 1, 0, 0, 0));
        default: ;
      endcase
      adv();
    end
    check_int("frame_done_pulses", fd_cnt, 1);

    // ---------------- overrun under long CPU hold (cycles 46..80) ----------------
    wen_cnt = 0;
    for (int k = 46; k <= 80; k++) begin
      cpu_wen = (k <= 74);
      ch0 = (k < 50) ? 32'hBB : 32'hDD;
      ch1 = (k < 50) ? 32'hCC : 32'hEE;
      @(negedge clock);
      if (k <= 78) wen_cnt += int'(ram_wen);
      case (k)
        50: check("ovr_stall",   cur(), mk(0, 12'h801, fmt(32'hBB, 5), 1, 1, 0, 0));
        56: check("ovr_1",       cur(), mk(0, 12'h801, fmt(32'hBB, 5), 1, 1, 0, 1));
        64: check("ovr_2",       cur(), mk(0, 12'h801, fmt(32'hBB, 5), 1, 1, 0, 2));
        74: check("ovr_3",       cur(), mk(0, 12'h801, fmt(32'hBB, 5), 1, 1, 0, 3));
        75: check("ovr_rel_ch0", cur(), mk(1, 12'h801, fmt(32'hBB, 5), 1, 1, 0, 3));
        76: check("ovr_rel_ch1", cur(), mk(1, 12'hA81, fmt(32'hCC, 5), 2, 1, 0, 3));
        80: check("ovr_next",    cur(), mk(1, 12'h802, fmt(32'hDD, 6), 2, 2, 0, 3));
        default: ;
      endcase
      adv();
    end
    check_int("ovr_single_pair", wen_cnt, 2);

    // ---------------- reset while in PEND1 ----------------
    reset = 1'b1;
    #1;
    check("reset_in_pend1", cur(), mk(0, 12'h800, 32'h0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    cyc    = 0;

    // ---------------- enable gating and timestamp data (cycles 0..21) ----------------
    wen_cnt = 0;
    for (int k = 0; k <= 21; k++) begin
      enable  = (k >= 5);
      cpu_wen = 1'b0;
      ch0 = 32'hABCD1234;
      ch1 = 32'h56789ABC;
      @(negedge clock);
      if (k <= 12) wen_cnt += int'(ram_wen);
      case (k)
        13: check("post_reset_ch0", cur(), mk(1, 12'h800, fmt(32'hABCD1234, 0), 0, 0, 0, 0));
        14: check("post_reset_ch1", cur(), mk(1, 12'hA80, fmt(32'h56789ABC, 0), 1, 0, 0, 0));
        21: check("second_pair",    cur(), mk(1, 12'h801, fmt(32'hABCD1234, 1), 1, 1, 0, 0));
        default: ;
      endcase
      adv();
    end
    check_int("enable_low_no_write", wen_cnt, 0);

    // ---------------- overrun saturation (cycles 22..2200) ----------------
    wen_cnt = 0;
    for (int k = 22; k <= 2200; k++) begin
      cpu_wen = (k >= 23 && k <= 2199);
      @(negedge clock);
      if (k >= 23 && k <= 2199) wen_cnt += int'(ram_wen);
      case (k)
        2068: check_int("ovr_254", int'(overrun_cnt), 254);
        2069: check_int("ovr_255", int'(overrun_cnt), 255);
        2199: check_int("ovr_sat", int'(overrun_cnt), 255);
        2200: check("sat_release", cur(), mk(1, 12'h802, fmt(32'hABCD1234, 2), 2, 2, 0, 8'd255));
        default: ;
      endcase
      adv();
    end
    check_int("sat_no_write", wen_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
